// File: rtl/mp_skill_scheduler_pkg.sv
// Shared player-action types: attribute width, legacy sort entry and the
// skill scheduler state encoding.
package usertype;

    typedef logic [15:0] Attribute;

    // Fixed-size buffer entry of the original four-skill evaluation.
    typedef struct packed {
        Attribute   attr;
        logic [1:0] stable_idx;
    } sorting_element_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_DONE
    } skill_sched_state_t;

endpackage

// File: rtl/mp_skill_scheduler_sorted_insert_buffer.sv
// Ascending cost buffer with one-cycle stable insertion, synchronous clear
// and an indexed read port.
module sorted_insert_buffer #(
    parameter int N_SKILL = 4,
    parameter int ATTR_W  = 16,
    parameter int IDX_W   = $clog2(N_SKILL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ins,
    input  logic [ATTR_W-1:0] ins_cost,
    input  logic [IDX_W-1:0]  ins_idx,
    input  logic [IDX_W-1:0]  rd_sel,
    output logic [ATTR_W-1:0] rd_cost,
    output logic [IDX_W-1:0]  rd_idx
);

    typedef struct packed {
        logic [ATTR_W-1:0] cost;
        logic [IDX_W-1:0]  idx;
    } entry_t;

    entry_t             ent     [N_SKILL];
    entry_t             ent_nxt [N_SKILL];
    logic [N_SKILL-1:0] vld;
    logic [N_SKILL-1:0] vld_nxt;
    logic [N_SKILL-1:0] le;

    // le is a prefix of ones because valid entries are sorted and packed
    // from slot 0, so the first clear bit marks the insertion slot.
    always_comb begin
        for (int unsigned i = 0; i < N_SKILL; i++) begin
            le[i] = vld[i] && (ent[i].cost <= ins_cost);
        end
        for (int unsigned i = 0; i < N_SKILL; i++) begin
            ent_nxt[i] = ent[i];
        end
        vld_nxt = vld;
        if (!le[0]) begin
            ent_nxt[0] = '{cost: ins_cost, idx: ins_idx};
            vld_nxt[0] = 1'b1;
        end
        for (int unsigned i = 1; i < N_SKILL; i++) begin
            if (!le[i]) begin
                if (le[i-1]) begin
                    ent_nxt[i] = '{cost: ins_cost, idx: ins_idx};
                    vld_nxt[i] = 1'b1;
                end else begin
                    ent_nxt[i] = ent[i-1];
                    vld_nxt[i] = vld[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int unsigned i = 0; i < N_SKILL; i++) ent[i] <= '0;
        end else if (clr) begin
            vld <= '0;
            for (int unsigned i = 0; i < N_SKILL; i++) ent[i] <= '0;
        end else if (ins) begin
            vld <= vld_nxt;
            for (int unsigned i = 0; i < N_SKILL; i++) ent[i] <= ent_nxt[i];
        end
    end

    assign rd_cost = ent[rd_sel].cost;
    assign rd_idx  = ent[rd_sel].idx;

endmodule

// File: rtl/mp_skill_scheduler.sv
// Greedy MP skill scheduler: stable-sorts N skill costs on arrival, then
// casts smallest-first until the first skill that does not fit.
module mp_skill_scheduler
    import usertype::*;
#(
    parameter int N_SKILL = 4,
    parameter int ATTR_W  = 16,
    parameter int CNT_W   = $clog2(N_SKILL+1),
    parameter int IDX_W   = $clog2(N_SKILL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [ATTR_W-1:0]  in_cost,
    input  logic [ATTR_W-1:0]  mp_in,
    output logic               busy,
    output logic               out_valid,
    output logic [CNT_W-1:0]   out_count,
    output logic [ATTR_W-1:0]  out_mp,
    output logic [N_SKILL-1:0] out_mask
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SKILL - 1);

    skill_sched_state_t state, state_nxt;

    logic [IDX_W-1:0]   cnt;
    logic [ATTR_W-1:0]  rem;
    logic [CNT_W-1:0]   count;
    logic [N_SKILL-1:0] mask;
    logic               fail;
    logic               ins, clr;
    logic [ATTR_W-1:0]  rd_cost;
    logic [IDX_W-1:0]   rd_idx;

    sorted_insert_buffer #(
        .N_SKILL (N_SKILL),
        .ATTR_W  (ATTR_W),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .ins      (ins),
        .ins_cost (in_cost),
        .ins_idx  (cnt),
        .rd_sel   (cnt),
        .rd_cost  (rd_cost),
        .rd_idx   (rd_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ins       = 1'b0;
        clr       = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    ins       = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    ins = 1'b1;
                    if (cnt == LAST) state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                clr       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // cnt is the stable index while loading and the sorted read slot while
    // accumulating; it returns to zero on every phase boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rem   <= '0;
            count <= '0;
            mask  <= '0;
            fail  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        rem <= mp_in;
                        cnt <= IDX_W'(1);
                    end
                end
                S_LOAD: begin
                    if (in_valid) cnt <= (cnt == LAST) ? '0 : cnt + IDX_W'(1);
                end
                S_ACCUM: begin
                    if (!fail && (rd_cost <= rem)) begin
                        rem          <= rem - rd_cost;
                        count        <= count + CNT_W'(1);
                        mask[rd_idx] <= 1'b1;
                    end else begin
                        fail <= 1'b1;
                    end
                    cnt <= (cnt == LAST) ? '0 : cnt + IDX_W'(1);
                end
                default: begin
                    cnt   <= '0;
                    rem   <= '0;
                    count <= '0;
                    mask  <= '0;
                    fail  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_count = out_valid ? count : '0;
    assign out_mp    = out_valid ? rem   : '0;
    assign out_mask  = out_valid ? mask  : '0;

endmodule

// File: doc/mp_skill_scheduler.md
# mp_skill_scheduler

Parametrised successor to the four-skill Use_Skill evaluation, generalised to N skills and a configurable attribute width. It accepts a player's available MP and N skill MP costs. It stable-sorts the costs ascending as they arrive, then greedily spends MP smallest-first. It reports the number of skills cast, the remaining MP and a per-skill usage mask. It sits between the input-decode stage and the DRAM write-back stage of the player action engine.

## Interface
- N_SKILL, 4, number of skill costs per request (≥2)
- ATTR_W, 16, width of MP and cost values (matches Attribute at default)
- CNT_W, $clog2(N_SKILL+1), width of out_count (derived)
- IDX_W, $clog2(N_SKILL), width of stable index (derived)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  qualifies in_cost (and mp_in on first beat)
- in_cost  in  ATTR_W  one skill MP cost per valid beat, in original index order 0..N_SKILL-1
- mp_in  in  ATTR_W  available MP, sampled on first in_valid beat of a request only
- busy  out  1  high from first accepted beat until out_valid cycle inclusive
- out_valid  out  1  one-cycle pulse, result valid
- out_count  out  CNT_W  number of skills cast
- out_mp  out  ATTR_W  MP remaining after casting
- out_mask  out  N_SKILL  bit i set = skill with original index i cast

## Operation
- States: S_IDLE, S_LOAD, S_ACCUM, S_DONE.
- S_IDLE:
  - in_valid → store mp_in and cost[0] at stable idx 0.
  - load counter = 1, go S_LOAD (S_ACCUM directly if N_SKILL=1 is disallowed; N_SKILL≥2).
- S_LOAD:
  - Each in_valid beat inserts {cost, idx=counter} into the sorted buffer in one cycle.
  - Stable insertion: placed after all entries with cost ≤ new cost.
  - Gaps (in_valid low) allowed; counter holds.
  - After beat N_SKILL-1 accepted → S_ACCUM.
- S_ACCUM: exactly N_SKILL cycles, walk sorted entries k=0..N_SKILL-1.
  - If no failure yet and cost_k ≤ remaining: remaining −= cost_k, count++, mask[idx_k]=1.
  - Else: set failure flag; no later entry is cast, even if it would fit.
  - Then → S_DONE.
- S_DONE: drive out_valid=1 with results for one cycle, clear buffer/flags, → S_IDLE.
- Arithmetic:
  - Compare unsigned ATTR_W; subtraction only after a passing compare, so no underflow/wrap.
  - Zero-cost skills are always cast if reached before a failure.
- in_valid while in S_ACCUM/S_DONE: ignored, not buffered.
- rst_n low at any time (including mid-load or mid-accumulate): immediate return to S_IDLE, buffer and counters cleared, partial request discarded, no out_valid.

## Timing
- Reset values: busy=0, out_valid=0, out_count=0, out_mp=0, out_mask=0.
- out_count/out_mp/out_mask are zero whenever out_valid=0.
- Latency: out_valid asserted N_SKILL+1 cycles after the cycle of the last accepted in_valid beat (fixed, data-independent).
- Minimum request period: 2·N_SKILL+1 cycles; a new first beat is accepted the cycle after out_valid.
- busy rises the cycle after the first beat and falls the cycle after out_valid.

## Structure
- Shared package usertype: add state enum skill_sched_state_t (S_IDLE, S_LOAD, S_ACCUM, S_DONE).
- Existing sorting_element_t (Attribute + 2-bit stable_idx) is the N_SKILL=4/ATTR_W=16 instance of the buffer entry.
- Parametrised entries are declared locally as packed {cost[ATTR_W], idx[IDX_W]}.
- One sub-module: sorted_insert_buffer (parameters N_SKILL, ATTR_W):
  - one-cycle stable insertion, clear input, indexed read port;
  - owns the parallel compare/shift network.
- The top owns the FSM, counters and accumulator.

## Test plan
- N=4, mp=35, costs 30,10,20,10 → out_count=2, out_mp=15, out_mask=4'b1010; out_valid 5 cycles after last beat.
- N=4, mp=0, costs 0,5,0,5 → count=2, mp=0, mask=4'b0101 (zero-cost cast, stable order).
- N=4, mp=65535, costs 1,2,3,4 → count=4, mp=65525, mask=4'b1111.
- N=4, mp=12, costs 13,1,1,20 with two idle gaps between beats and in_valid pulses during S_ACCUM → count=2, mp=10, mask=4'b0110; extra beats ignored; latency measured from last accepted beat.
- rst_n pulsed low in 2nd S_ACCUM cycle → all outputs 0 immediately, no out_valid. Next request mp=8, costs 8,8,8,8 → count=1, mp=0, mask=4'b0001.
- N_SKILL=8, ATTR_W=8, mp=200, costs 50,50,50,50,50,1,2,3 → count=6, mp=44, mask=8'b11100111.
